peripheral_responder: RTL

//  Memory-mapped peripheral slave on the CPU's MEM-stage peripheral bus (addr[30]=1 region).

---
 rtl/peripheral_bus_if.sv | 27 ++
 rtl/peripheral_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/peripheral_bus_if.sv
// CPU MEM-stage peripheral bus: access request from the CPU, read data and interrupt back from the slave.
interface peripheral_bus_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output rd,
        output wr,
        output addr,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  rd,
        input  wr,
        input  addr,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/peripheral_responder.sv
// Peripheral slave for the addr[30] region: reload timer with overflow IRQ, LED/7-seg registers,
// switch readback and a free-running systick, with same-cycle combinational read data.
module peripheral_responder #(
    parameter int unsigned LED_W  = 8,
    parameter int unsigned SW_W   = 8,
    parameter int unsigned DIGI_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    peripheral_bus_if.slave   bus,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   switch,
    output logic [DIGI_W-1:0] digi
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TCON_W  = 3;
    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_IS = 2;

    typedef enum logic [2:0] {
        REG_TH      = 3'd0,
        REG_TL      = 3'd1,
        REG_TCON    = 3'd2,
        REG_LED     = 3'd3,
        REG_SWITCH  = 3'd4,
        REG_DIGI    = 3'd5,
        REG_SYSTICK = 3'd6,
        REG_NONE    = 3'd7
    } regSel_e;

    logic              inRegion;
    regSel_e           regSel;
    logic              wrEn;
    logic              wrTh;
    logic              wrTl;
    logic              wrTcon;
    logic              wrLed;
    logic              wrDigi;
    logic              unusedAddrBits;

    logic [DATA_W-1:0] th;
    logic [DATA_W-1:0] tl;
    logic [TCON_W-1:0] tcon;
    logic [DATA_W-1:0] systick;

    logic [DATA_W-1:0] thNext;
    logic [DATA_W-1:0] tlNext;
    logic [TCON_W-1:0] tconNext;
    logic [LED_W-1:0]  ledNext;
    logic [DIGI_W-1:0] digiNext;
    logic              overflow;

    // Address decode: only word index bits and the region bit matter
    assign inRegion       = bus.addr[30];
    assign regSel         = regSel_e'(bus.addr[4:2]);
    assign unusedAddrBits = ^{bus.addr[31], bus.addr[29:5], bus.addr[1:0]};

    assign wrEn   = bus.wr & inRegion;
    assign wrTh   = wrEn && (regSel == REG_TH);
    assign wrTl   = wrEn && (regSel == REG_TL);
    assign wrTcon = wrEn && (regSel == REG_TCON);
    assign wrLed  = wrEn && (regSel == REG_LED);
    assign wrDigi = wrEn && (regSel == REG_DIGI);

    // Timer advance/reload, then CPU writes override whatever the timer produced
    always_comb begin
        thNext   = th;
        tlNext   = tl;
        tconNext = tcon;
        ledNext  = led;
        digiNext = digi;
        overflow = 1'b0;

        if (tcon[TCON_EN]) begin
            if (tl == '1) begin
                tlNext   = th;
                overflow = tcon[TCON_IE] && !wrTl;
            end else begin
                tlNext = tl + DATA_W'(1);
            end
        end

        if (overflow) begin
            tconNext[TCON_IS] = 1'b1;
        end

        if (wrTh) begin
            thNext = bus.wdata;
        end
        if (wrTl) begin
            tlNext = bus.wdata;
        end
        if (wrTcon) begin
            tconNext = bus.wdata[TCON_W-1:0];
        end
        if (wrLed) begin
            ledNext = bus.wdata[LED_W-1:0];
        end
        if (wrDigi) begin
            digiNext = bus.wdata[DIGI_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            led     <= '0;
            digi    <= '0;
            systick <= '0;
        end else begin
            th      <= thNext;
            tl      <= tlNext;
            tcon    <= tconNext;
            led     <= ledNext;
            digi    <= digiNext;
            systick <= systick + DATA_W'(1);
        end
    end

    // Read mux shows pre-write register state; MemRead is not region-qualified upstream
    always_comb begin
        bus.rdata = '0;
        if (bus.rd && inRegion) begin
            case (regSel)
                REG_TH:      bus.rdata = th;
                REG_TL:      bus.rdata = tl;
                REG_TCON:    bus.rdata = DATA_W'(tcon);
                REG_LED:     bus.rdata = DATA_W'(led);
                REG_SWITCH:  bus.rdata = DATA_W'(switch);
                REG_DIGI:    bus.rdata = DATA_W'(digi);
                REG_SYSTICK: bus.rdata = systick;
                default:     bus.rdata = '0;
            endcase
        end
    end

    assign bus.irq = tcon[TCON_IE] & tcon[TCON_IS];

endmodule
